mult_div_unit: RTL and testbench

Multiply/divide unit in the EX stage, consuming the Multop/Start/operand fields the ID/EX pipeline register presents. Holds the HI/LO architectural registers and runs multi-cycle mult/multu/div/divu with a busy countdown. Serves mfhi/mflo reads and mthi/mtlo writes. Exports Busy so the hazard unit can stall later MD instructions in ID.

---
 rtl/mult_div_unit.sv | 119 +++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage multiply/divide unit with HI/LO registers and busy countdown
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  Multop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pend_hi, r_pend_lo;
  logic        r_pend_wr;
  logic        r_busy;
  logic [31:0] r_count;

  logic        w_is_md_op;
  logic        w_launch;
  logic        w_div_zero;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur;
  logic [31:0] w_next_hi, w_next_lo;

  assign w_is_md_op = (Multop >= OP_MULT) && (Multop <= OP_DIVU);
  assign w_launch   = Start && w_is_md_op && !Req && !r_busy;
  assign w_div_zero = (Multop == OP_DIV || Multop == OP_DIVU) && (B == 32'd0);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide goes through magnitudes so INT_MIN / -1 wraps to 0x80000000 with remainder 0.
  assign w_abs_a = A[31] ? -A : A;
  assign w_abs_b = B[31] ? -B : B;
  assign w_uq    = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
  assign w_ur    = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;

  always_comb begin
    w_next_hi = 32'd0;
    w_next_lo = 32'd0;
    case (Multop)
      OP_MULT: begin
        w_next_hi = w_prod_s[63:32];
        w_next_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_next_hi = w_prod_u[63:32];
        w_next_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        w_next_lo = (A[31] ^ B[31]) ? -w_uq : w_uq;
        w_next_hi = A[31] ? -w_ur : w_ur;
      end
      OP_DIVU: begin
        w_next_lo = (B == 32'd0) ? 32'd0 : A / B;
        w_next_hi = (B == 32'd0) ? 32'd0 : A % B;
      end
      default: begin
        w_next_hi = 32'd0;
        w_next_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= 32'd0;
    end else if (w_launch) begin
      r_pend_hi <= w_next_hi;
      r_pend_lo <= w_next_lo;
      r_pend_wr <= !w_div_zero;
      r_busy    <= 1'b1;
      r_count   <= (Multop == OP_MULT || Multop == OP_MULTU) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
    end else if (r_busy) begin
      r_count <= r_count - 32'd1;
      if (r_count == 32'd1) begin
        r_busy    <= 1'b0;
        r_pend_wr <= 1'b0;
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (!Req) begin
      if (Multop == OP_MTHI) r_hi <= A;
      if (Multop == OP_MTLO) r_lo <= A;
    end
  end

  assign Busy  = r_busy;
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MDout = (Multop == OP_MFHI) ? r_hi :
                 (Multop == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  Multop;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO, MDout;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Multop(Multop),
    .A(A), .B(B), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDout(MDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Multop = op; A = a; B = b;
    tick();
    Start = 1'b0; Multop = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;
  logic [31:0] prev_hi, prev_lo;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{4'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[7] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[8] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9] = '{4'd3, 32'h00000005, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 10};

    reset = 1'b0; Start = 1'b0; Multop = 4'd0; A = 32'd0; B = 32'd0; Req = 1'b0;
    tick(); tick();
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;
    tick();

    prev_hi = 32'd0; prev_lo = 32'd0;
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_start", i), {31'd0, Busy}, 32'd1);
      check($sformatf("v%0d_hi_held", i), HI, prev_hi);
      check($sformatf("v%0d_lo_held", i), LO, prev_lo);
      wait_done(n);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      prev_hi = vecs[i].hi; prev_lo = vecs[i].lo;
    end

    // mthi / mtlo and MDout read mux
    Multop = 4'd7; A = 32'h12345678;
    tick();
    Multop = 4'd5; A = 32'd0;
    #1;
    check("mfhi_after_mthi", MDout, 32'h12345678);
    Multop = 4'd6;
    #1;
    check("mflo_read", MDout, 32'h00000001);
    Multop = 4'd0;
    #1;
    check("mdout_none", MDout, 32'd0);
    Multop = 4'd8; A = 32'hDEADBEEF; Req = 1'b1;
    tick();
    Req = 1'b0; Multop = 4'd0;
    check("mtlo_req_blocked", LO, 32'h00000001);
    Multop = 4'd8; A = 32'hCAFEF00D;
    tick();
    Multop = 4'd6; A = 32'd0;
    #1;
    check("mtlo_write", MDout, 32'hCAFEF00D);
    Multop = 4'd0;

    // launch blocked by Req, and by non-MD Multop
    Req = 1'b1;
    launch(4'd1, 32'd9, 32'd9);
    Req = 1'b0;
    check("req_no_launch_busy", {31'd0, Busy}, 32'd0);
    tick(); tick();
    check("req_no_launch_hi", HI, 32'h12345678);
    check("req_no_launch_lo", LO, 32'hCAFEF00D);
    launch(4'd5, 32'd9, 32'd9);
    check("bad_op_no_launch", {31'd0, Busy}, 32'd0);

    // Req pulse during div does not cancel it: 100/7 -> q=14 r=2
    launch(4'd3, 32'd100, 32'd7);
    tick(); tick();
    Req = 1'b1;
    tick();
    Req = 1'b0;
    wait_done(n);
    check("req_mid_div_cycles", n + 3, 32'd10);
    check("req_mid_div_lo", LO, 32'h0000000E);
    check("req_mid_div_hi", HI, 32'h00000002);

    // second Start while busy is ignored: 6*7 = 42
    launch(4'd1, 32'd6, 32'd7);
    tick();
    launch(4'd1, 32'd1, 32'd1);
    wait_done(n);
    check("restart_cycles", n + 2, 32'd5);
    check("restart_lo", LO, 32'd42);
    check("restart_hi", HI, 32'd0);

    // async reset mid-operation aborts without a later write
    launch(4'd2, 32'hFFFFFFFF, 32'h00000010);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("rst_after_busy", {31'd0, Busy}, 32'd0);
    check("rst_after_hi", HI, 32'd0);
    check("rst_after_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
